relu_maxpool_2x2: RTL

- Post-convolution stage placed directly downstream of the conv controller.
- Consumes the controller's valid-qualified 16-bit signed ofmap pixel stream in row-major order.
- Applies ReLU, then 2x2 stride-2 max pooling, and emits one pooled pixel per 2x2 window.
- Signals completion of each frame to the next layer or to the host.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/relu_maxpool_2x2_if.sv | 23 ++
 rtl/pool_rowbuf.sv | 40 ++++
 rtl/relu_maxpool_2x2.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and pixel helpers for the CNN post-processing stages.
package cnn_pkg;

    localparam int unsigned DW_PIX = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } pool_state_e;

    // Unsigned max of two pixel words; callers only pass non-negative values.
    function automatic logic [DW_PIX-1:0] max_u(input logic [DW_PIX-1:0] a,
                                                input logic [DW_PIX-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // ReLU on a two's-complement pixel: negatives clamp to zero.
    function automatic logic [DW_PIX-1:0] relu(input logic [DW_PIX-1:0] x);
        return x[DW_PIX-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/relu_maxpool_2x2_if.sv
// Pixel stream in / pooled stream out bundle for relu_maxpool_2x2.
interface relu_maxpool_2x2_if #(
    parameter int unsigned DW = 16
);
    logic          start;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          conv_done;
    logic [DW-1:0] pool_out;
    logic          pool_valid;
    logic          done;
    logic          underrun;

    modport master (
        output start, din, din_valid, conv_done,
        input  pool_out, pool_valid, done, underrun
    );

    modport slave (
        input  start, din, din_valid, conv_done,
        output pool_out, pool_valid, done, underrun
    );
endinterface

// File: rtl/pool_rowbuf.sv
// Register-based row buffer holding horizontal pair maxima of the even row.
module pool_rowbuf #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // Next-state of the buffer: single indexed write, out-of-range writes dropped.
    always_comb begin
        mem_d = mem_q;
        if (we && (32'(waddr) < DEPTH)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Buffer registers, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = (32'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/relu_maxpool_2x2.sv
// ReLU followed by 2x2 stride-2 max pooling over a row-major ofmap stream.
module relu_maxpool_2x2
    import cnn_pkg::*;
#(
    parameter int unsigned DW   = DW_PIX,
    parameter int unsigned OF_W = 2,
    parameter int unsigned OF_H = 2,
    parameter int unsigned CW   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    relu_maxpool_2x2_if.slave  bus
);

    localparam int unsigned RB_DEPTH = (OF_W + 1) / 2;
    localparam int unsigned RB_AW    = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(OF_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(OF_H - 1);

    pool_state_e   state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [DW-1:0] pool_out_q, pool_out_d;
    logic          pool_valid_q, pool_valid_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;

    logic [DW-1:0]    pix_r;
    logic [DW-1:0]    pair;
    logic [DW-1:0]    rb_rdata;
    logic             rb_we;
    logic [RB_AW-1:0] rb_addr;
    logic             last_accept;

    pool_rowbuf #(
        .DEPTH (RB_DEPTH),
        .DW    (DW),
        .AW    (RB_AW)
    ) u_rowbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rb_we),
        .waddr (rb_addr),
        .wdata (pair),
        .raddr (rb_addr),
        .rdata (rb_rdata)
    );

    // Pixel datapath: rectified input and horizontal pair maximum.
    always_comb begin
        pix_r   = DW'(relu(DW_PIX'(bus.din)));
        pair    = DW'(max_u(DW_PIX'(hold_q), DW_PIX'(pix_r)));
        rb_addr = RB_AW'(col_q >> 1);
    end

    // FSM next state, counters, window reduction and output pulses.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        pool_out_d   = pool_out_q;
        pool_valid_d = 1'b0;
        done_d       = 1'b0;
        underrun_d   = underrun_q;
        rb_we        = 1'b0;
        last_accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    col_d      = '0;
                    row_d      = '0;
                    underrun_d = 1'b0;
                    state_d    = RUN;
                end
            end

            RUN: begin
                if (bus.din_valid) begin
                    // Even column parks the pixel; odd column closes a pair.
                    if (!col_q[0]) begin
                        hold_d = pix_r;
                    end else if (!row_q[0]) begin
                        rb_we = 1'b1;
                    end else begin
                        pool_out_d   = DW'(max_u(DW_PIX'(rb_rdata), DW_PIX'(pair)));
                        pool_valid_d = 1'b1;
                    end

                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + CW'(1);
                        if (row_q == ROW_LAST) begin
                            last_accept = 1'b1;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end

                // Early upstream end flags underrun; a coinciding last pixel is a clean finish.
                if (bus.conv_done && !last_accept) begin
                    underrun_d = 1'b1;
                end

                if (last_accept || bus.conv_done) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                end
            end

            FIN: begin
                col_d   = '0;
                row_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            pool_out_q   <= '0;
            pool_valid_q <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            pool_out_q   <= pool_out_d;
            pool_valid_q <= pool_valid_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.pool_out   = pool_out_q;
    assign bus.pool_valid = pool_valid_q;
    assign bus.done       = done_q;
    assign bus.underrun   = underrun_q;

endmodule
